// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects, FSM states
// and the register-match helper used by the forwarding compare.
package hazard_pkg;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_t;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      MEMWAIT = 2'd1,
      ERR     = 2'd2
   } hz_state_t;

   localparam logic [4:0] REG_ZERO = 5'd0;

   // x0 is hardwired to zero, so a write to it can never be a forwarding source.
   function automatic logic reg_match(input logic [4:0] rd, input logic [4:0] rs);
      return (rd != REG_ZERO) && (rd == rs);
   endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// Forwarding select for one Execute-stage operand; the Memory-stage result
// has priority over the Writeback result because it is the younger value.
module fwd_unit
   import hazard_pkg::*;
(
   input  logic [4:0] rs_e,
   input  logic [4:0] rd_m,
   input  logic       reg_write_m,
   input  logic [4:0] rd_w,
   input  logic       reg_write_w,
   output fwd_sel_t   sel
);

   always_comb begin
      sel = FWD_RF;
      if (reg_write_m && reg_match(rd_m, rs_e)) begin
         sel = FWD_MEM;
      end else if (reg_write_w && reg_match(rd_w, rs_e)) begin
         sel = FWD_WB;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline: forwarding, load-use stall,
// branch flush and memory-wait freeze with timeout. Optional HAZARD_PERF_EN adds perf counters.
//
// state   | meaning
// --------+-----------------------------------------------------------
// RUN     | normal flow, no outstanding memory wait
// MEMWAIT | data memory busy, pipeline frozen, wait timer running
// ERR     | memory timed out, pipeline frozen until reset (MemErr=1)
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       Rs1D,
   input  logic [4:0]       Rs2D,
   input  logic [4:0]       Rs1E,
   input  logic [4:0]       Rs2E,
   input  logic [4:0]       RdE,
   input  logic             ResultSrcE0,
   input  logic             PCSrcE,
   input  logic [4:0]       RdM,
   input  logic             RegWriteM,
   input  logic [4:0]       RdW,
   input  logic             RegWriteW,
   input  logic             MemReqM,
   input  logic             MemReadyM,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             StallM,
   output logic             FlushD,
   output logic             FlushE,
   output logic             FlushW,
   output logic             MemErr,
   output logic [CNT_W-1:0] StallCnt,
   output logic [CNT_W-1:0] FlushCnt
);

   localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
   // Timer counts down the remaining wait budget; zero is the terminal count.
   localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
   localparam logic [WAIT_W-1:0] WAIT_IDLE = WAIT_W'(MEM_TIMEOUT);
   localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

   hz_state_t         state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              mem_err_q, mem_err_d;

   fwd_sel_t fwd_a, fwd_b;
   logic     lw_stall;
   logic     mem_stall;

   fwd_unit u_fwd_a (
      .rs_e        (Rs1E),
      .rd_m        (RdM),
      .reg_write_m (RegWriteM),
      .rd_w        (RdW),
      .reg_write_w (RegWriteW),
      .sel         (fwd_a)
   );

   fwd_unit u_fwd_b (
      .rs_e        (Rs2E),
      .rd_m        (RdM),
      .reg_write_m (RegWriteM),
      .rd_w        (RdW),
      .reg_write_w (RegWriteW),
      .sel         (fwd_b)
   );

   assign ForwardAE = reset ? FWD_RF : fwd_a;
   assign ForwardBE = reset ? FWD_RF : fwd_b;

   assign lw_stall  = ResultSrcE0 && (RdE != REG_ZERO) && ((Rs1D == RdE) || (Rs2D == RdE));
   assign mem_stall = (MemReqM && !MemReadyM) || (state_q == ERR);

   always_comb begin
      StallF = 1'b0;
      StallD = 1'b0;
      StallE = 1'b0;
      StallM = 1'b0;
      FlushD = 1'b0;
      FlushE = 1'b0;
      FlushW = 1'b0;
      if (reset) begin
         FlushD = 1'b1;
         FlushE = 1'b1;
         FlushW = 1'b1;
      end else if (mem_stall) begin
         // Freeze everything; pending branch/load-use flushes resolve after release.
         StallF = 1'b1;
         StallD = 1'b1;
         StallE = 1'b1;
         StallM = 1'b1;
         FlushW = 1'b1;
      end else begin
         StallF = lw_stall;
         StallD = lw_stall;
         FlushE = lw_stall || PCSrcE;
         FlushD = PCSrcE;
      end
   end

   always_comb begin
      state_d   = state_q;
      wait_d    = wait_q;
      mem_err_d = mem_err_q;
      case (state_q)
         RUN: begin
            if (mem_stall) begin
               state_d = MEMWAIT;
               wait_d  = WAIT_LOAD;
            end else begin
               wait_d  = WAIT_IDLE;
            end
         end
         MEMWAIT: begin
            if (MemReadyM || !MemReqM) begin
               state_d = RUN;
               wait_d  = WAIT_IDLE;
            end else if ((MEM_TIMEOUT != 0) && (wait_q == '0)) begin
               state_d   = ERR;
               mem_err_d = 1'b1;
            end else if (MEM_TIMEOUT != 0) begin
               wait_d = wait_q - WAIT_ONE;
            end
         end
         ERR: begin
            state_d   = ERR;
            mem_err_d = 1'b1;
         end
         default: begin
            state_d = RUN;
            wait_d  = WAIT_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= RUN;
         wait_q    <= WAIT_IDLE;
         mem_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         mem_err_q <= mem_err_d;
      end
   end

   assign MemErr = mem_err_q;

`ifdef HAZARD_PERF_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if ((StallF || StallD || StallE || StallM) && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if ((FlushD || FlushE) && !reset && (flush_cnt_q != '1)) begin
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign StallCnt = stall_cnt_q;
   assign FlushCnt = flush_cnt_q;
`else
   assign StallCnt = '0;
   assign FlushCnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (MEM_TIMEOUT=4): forwarding, load-use, branch,
// memory wait/release, timeout to error, reset recovery and perf counters.
module tb_hazard_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
   logic        ResultSrcE0, PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM;
   logic [1:0]  ForwardAE, ForwardBE;
   logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
   logic [31:0] StallCnt, FlushCnt;
   logic [6:0]  ctl;

   int n_checks = 0;
   int n_fail   = 0;

   // {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
   localparam logic [6:0] CTL_IDLE   = 7'b0000000;
   localparam logic [6:0] CTL_RESET  = 7'b0000111;
   localparam logic [6:0] CTL_LW     = 7'b1100010;
   localparam logic [6:0] CTL_BR     = 7'b0000110;
   localparam logic [6:0] CTL_LW_BR  = 7'b1100110;
   localparam logic [6:0] CTL_FREEZE = 7'b1111001;

   always #5 clk = ~clk;

   assign ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

   hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
      .clk         (clk),
      .reset       (reset),
      .Rs1D        (Rs1D),
      .Rs2D        (Rs2D),
      .Rs1E        (Rs1E),
      .Rs2E        (Rs2E),
      .RdE         (RdE),
      .ResultSrcE0 (ResultSrcE0),
      .PCSrcE      (PCSrcE),
      .RdM         (RdM),
      .RegWriteM   (RegWriteM),
      .RdW         (RdW),
      .RegWriteW   (RegWriteW),
      .MemReqM     (MemReqM),
      .MemReadyM   (MemReadyM),
      .ForwardAE   (ForwardAE),
      .ForwardBE   (ForwardBE),
      .StallF      (StallF),
      .StallD      (StallD),
      .StallE      (StallE),
      .StallM      (StallM),
      .FlushD      (FlushD),
      .FlushE      (FlushE),
      .FlushW      (FlushW),
      .MemErr      (MemErr),
      .StallCnt    (StallCnt),
      .FlushCnt    (FlushCnt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic idle_inputs();
      Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
      ResultSrcE0 = 0; PCSrcE = 0; RegWriteM = 0; RegWriteW = 0;
      MemReqM = 0; MemReadyM = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      idle_inputs();
      reset = 1'b1;
      step();
      step();

      // Reset overrides: flushes high, no stalls, forwarding forced to register file
      Rs1E = 5; RdM = 5; RegWriteM = 1;
      #1;
      check("reset_ctl", 32'(ctl), 32'(CTL_RESET));
      check("reset_fwd_a", 32'(ForwardAE), 32'h0);
      check("reset_memerr", 32'(MemErr), 32'h0);

      reset = 1'b0;
      idle_inputs();
      step();
      check("run_idle_ctl", 32'(ctl), 32'(CTL_IDLE));
      check("run_idle_cnt", StallCnt, 32'h0);

      // Forwarding priority and fall-through
      Rs1E = 5; RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs2E = 9;
      #1;
      check("fwd_a_mem", 32'(ForwardAE), 32'h2);
      check("fwd_b_none", 32'(ForwardBE), 32'h0);
      RegWriteM = 0;
      #1;
      check("fwd_a_wb", 32'(ForwardAE), 32'h1);
      RegWriteM = 1; RdM = 0; RdW = 0; Rs1E = 0;
      #1;
      check("fwd_a_x0", 32'(ForwardAE), 32'h0);
      Rs2E = 6; RdW = 6; RegWriteW = 1; RdM = 3; RegWriteM = 1;
      #1;
      check("fwd_b_wb", 32'(ForwardBE), 32'h1);
      RdM = 6;
      #1;
      check("fwd_b_mem", 32'(ForwardBE), 32'h2);
      idle_inputs();

      // Load-use on Rs2D, then Rs1D, then RdE = x0
      ResultSrcE0 = 1; RdE = 7; Rs2D = 7;
      #1;
      check("lw_rs2", 32'(ctl), 32'(CTL_LW));
      step();
      ResultSrcE0 = 0;
      #1;
      check("lw_released", 32'(ctl), 32'(CTL_IDLE));
      ResultSrcE0 = 1; Rs2D = 0; Rs1D = 7;
      #1;
      check("lw_rs1", 32'(ctl), 32'(CTL_LW));
      RdE = 0; Rs1D = 0;
      #1;
      check("lw_rd_x0", 32'(ctl), 32'(CTL_IDLE));

      // Branch alone, then together with a load-use
      idle_inputs();
      PCSrcE = 1;
      #1;
      check("branch", 32'(ctl), 32'(CTL_BR));
      ResultSrcE0 = 1; RdE = 7; Rs2D = 7;
      #1;
      check("branch_lw", 32'(ctl), 32'(CTL_LW_BR));
      step();
      idle_inputs();
      step();

      // Memory wait of 3 cycles with a branch held; ready cycle releases
      MemReqM = 1; MemReadyM = 0; PCSrcE = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check($sformatf("memwait_ctl_%0d", i), 32'(ctl), 32'(CTL_FREEZE));
         step();
      end
      MemReadyM = 1;
      #1;
      check("mem_ready_ctl", 32'(ctl), 32'(CTL_BR));
      check("mem_ready_err", 32'(MemErr), 32'h0);
      step();
      idle_inputs();
      step();
      check("after_wait_ctl", 32'(ctl), 32'(CTL_IDLE));
      check("after_wait_err", 32'(MemErr), 32'h0);

      // Timeout: 5 wait cycles with MEM_TIMEOUT=4, then sticky error
      MemReqM = 1; MemReadyM = 0;
      for (int i = 0; i < 5; i++) begin
         #1;
         check($sformatf("to_wait_err_%0d", i), 32'(MemErr), 32'h0);
         check($sformatf("to_wait_ctl_%0d", i), 32'(ctl), 32'(CTL_FREEZE));
         step();
      end
      check("to_err_set", 32'(MemErr), 32'h1);
      MemReadyM = 1;
      #1;
      check("err_ready_ctl", 32'(ctl), 32'(CTL_FREEZE));
      idle_inputs();
      step();
      check("err_sticky_ctl", 32'(ctl), 32'(CTL_FREEZE));
      check("err_sticky", 32'(MemErr), 32'h1);
      reset = 1'b1;
      #1;
      check("err_reset_ctl", 32'(ctl), 32'(CTL_RESET));
      step();
      reset = 1'b0;
      #1;
      check("err_cleared", 32'(MemErr), 32'h0);
      check("err_cleared_ctl", 32'(ctl), 32'(CTL_IDLE));
      step();

      // Perf counters: two load-use cycles and one branch cycle
      ResultSrcE0 = 1; RdE = 7; Rs2D = 7;
      step();
      idle_inputs();
      step();
      ResultSrcE0 = 1; RdE = 7; Rs1D = 7;
      step();
      idle_inputs();
      PCSrcE = 1;
      step();
      idle_inputs();
      #1;
`ifdef HAZARD_PERF_EN
      check("stall_cnt", StallCnt, 32'd2);
      check("flush_cnt", FlushCnt, 32'd3);
`else
      check("stall_cnt_off", StallCnt, 32'd0);
      check("flush_cnt_off", FlushCnt, 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
